neopixel_frame_seq: RTL and testbench

Upstream feeder for neopixel_tx_fsm. Holds a double-buffered GRB frame of NUM_PIXELS pixels and presents one 24-bit word per slot on neo_dIn. Runs the per-frame slot sequence: pixel slots with rgb_msgTyp=1, then latch slots with rgb_msgTyp=0, advancing on rd_next. Host logic writes the back bank and requests a bank swap, which is applied only at a frame boundary so a strip never shows a torn frame.

---
 rtl/neopixel_pkg.sv | 26 ++
 rtl/neopixel_pixel_ram.sv | 32 +++
 rtl/neopixel_frame_seq.sv | 162 ++++++++++++++++
 tb/tb_neopixel_frame_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// Shared types and default sizing for the NeoPixel frame sequencer and its pixel store.
package neopixel_pkg;

    localparam int GRB_W           = 24;
    localparam int DEF_NUM_PIXELS  = 18;
    localparam int DEF_LATCH_SLOTS = 14;
    localparam int DEF_ADDR_W      = 5;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_FETCH   = 2'd1,
        SEQ_PRESENT = 2'd2
    } seq_state_e;

    // Address width that stays legal for degenerate depths of 0 or 1.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neopixel_pixel_ram.sv
// Two-bank pixel store: one write port, one registered read port (EBR/distributed friendly).
module neopixel_pixel_ram
    import neopixel_pkg::*;
#(
    parameter int DEPTH = 2 * DEF_NUM_PIXELS,
    parameter int AW    = clog2_min1(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  pixel_t        wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output pixel_t        rd_data_o
);

    pixel_t mem_q [DEPTH];
    pixel_t rd_data_q;

    // No reset on the array or read register so the tools can map this to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/neopixel_frame_seq.sv
// Frame sequencer feeding neopixel_tx_fsm: double-buffered GRB frame, pixel slots then latch slots,
// bank swaps only at frame boundaries.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no word offered; applies pending swap, starts frame on run
//   FETCH   | one-cycle RAM read of the current slot's pixel
//   PRESENT | word valid on neo_dIn, waiting for rd_next
module neopixel_frame_seq
    import neopixel_pkg::*;
#(
    parameter int NUM_PIXELS  = DEF_NUM_PIXELS,
    parameter int LATCH_SLOTS = DEF_LATCH_SLOTS,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [GRB_W-1:0]  wr_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              frame_done,
    output logic [GRB_W-1:0]  neo_dIn,
    output logic              rgb_msgTyp,
    output logic              empty_flg,
    input  logic              rd_next
);

    localparam int TOTAL_SLOTS = NUM_PIXELS + LATCH_SLOTS;
    localparam int SLOT_W      = clog2_min1(TOTAL_SLOTS);
    localparam int RAM_DEPTH   = 2 * NUM_PIXELS;
    localparam int RAM_AW      = clog2_min1(RAM_DEPTH);

    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(TOTAL_SLOTS - 1);
    localparam logic [SLOT_W:0]   NPIX_SLOT  = (SLOT_W + 1)'(NUM_PIXELS);
    localparam logic [ADDR_W:0]   NPIX_ADDR  = (ADDR_W + 1)'(NUM_PIXELS);
    localparam logic [RAM_AW-1:0] BANK1_BASE = RAM_AW'(NUM_PIXELS);

    localparam logic [1:0] ST_IDLE    = SEQ_IDLE;
    localparam logic [1:0] ST_FETCH   = SEQ_FETCH;
    localparam logic [1:0] ST_PRESENT = SEQ_PRESENT;

    logic [1:0]        state_q, state_d;
    logic [SLOT_W-1:0] idx_q, idx_d;
    logic              disp_bank_q, disp_bank_d;
    logic              swap_pending_q, swap_pending_d;
    logic              msg_typ_q, msg_typ_d;
    logic              swap_ack_q, swap_ack_d;
    logic              frame_done_q, frame_done_d;

    logic              is_pixel_slot;
    logic              pend_eff;
    logic              ram_rd_en;
    logic              ram_wr_en;
    logic [RAM_AW-1:0] ram_wr_addr;
    logic [RAM_AW-1:0] ram_rd_addr;
    pixel_t            ram_rd_data;
    logic [GRB_W-1:0]  ram_rd_word;

    assign is_pixel_slot = ({1'b0, idx_q} < NPIX_SLOT);
    // A request arriving in the very cycle a swap is applied is absorbed by that swap.
    assign pend_eff      = swap_pending_q | swap_req;

    // Writes always target the bank that is not on display this cycle.
    assign ram_wr_en   = wr_en && ({1'b0, wr_addr} < NPIX_ADDR);
    assign ram_wr_addr = (disp_bank_q ? '0 : BANK1_BASE) + RAM_AW'(wr_addr);
    assign ram_rd_addr = (disp_bank_q ? BANK1_BASE : '0) + RAM_AW'(idx_q);

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        disp_bank_d    = disp_bank_q;
        swap_pending_d = pend_eff;
        msg_typ_d      = msg_typ_q;
        swap_ack_d     = 1'b0;
        frame_done_d   = 1'b0;
        ram_rd_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_eff) begin
                    disp_bank_d    = ~disp_bank_q;
                    swap_ack_d     = 1'b1;
                    swap_pending_d = 1'b0;
                end
                if (run) begin
                    idx_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ram_rd_en = is_pixel_slot;
                msg_typ_d = is_pixel_slot;
                state_d   = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (rd_next) begin
                    if (idx_q == LAST_SLOT) begin
                        frame_done_d = 1'b1;
                        idx_d        = '0;
                        if (pend_eff) begin
                            disp_bank_d    = ~disp_bank_q;
                            swap_ack_d     = 1'b1;
                            swap_pending_d = 1'b0;
                        end
                        state_d = run ? ST_FETCH : ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            disp_bank_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            msg_typ_q      <= 1'b0;
            swap_ack_q     <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            disp_bank_q    <= disp_bank_d;
            swap_pending_q <= swap_pending_d;
            msg_typ_q      <= msg_typ_d;
            swap_ack_q     <= swap_ack_d;
            frame_done_q   <= frame_done_d;
        end
    end

    neopixel_pixel_ram #(
        .DEPTH (RAM_DEPTH),
        .AW    (RAM_AW)
    ) u_pixel_ram (
        .clk       (clk),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (ram_wr_addr),
        .wr_data_i (pixel_t'(wr_data)),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (ram_rd_addr),
        .rd_data_o (ram_rd_data)
    );

    // The RAM read register is the word holder; msg type gates it so latch slots and reset give zero.
    assign ram_rd_word = ram_rd_data;
    assign neo_dIn     = msg_typ_q ? ram_rd_word : '0;
    assign rgb_msgTyp  = msg_typ_q;
    assign empty_flg   = (state_q != ST_PRESENT);
    assign swap_ack    = swap_ack_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_neopixel_frame_seq.sv
// Directed bench for neopixel_frame_seq: reset, frame streaming, bank swaps, ignored writes, stop and reset.
module tb_neopixel_frame_seq;

    localparam int NPIX  = 18;
    localparam int TOTAL = 32;
    localparam int GAP   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        swap_req = 1'b0;
    logic        rd_next = 1'b0;
    logic        swap_ack;
    logic        frame_done;
    logic [23:0] neo_dIn;
    logic        rgb_msgTyp;
    logic        empty_flg;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        disp = 1'b0;
    logic [23:0] model [2][NPIX];

    neopixel_frame_seq dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .frame_done (frame_done),
        .neo_dIn    (neo_dIn),
        .rgb_msgTyp (rgb_msgTyp),
        .empty_flg  (empty_flg),
        .rd_next    (rd_next)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = a[4:0];
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        if (a < NPIX) model[disp ? 0 : 1][a] = d;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_empty"}, empty_flg, 1'b1);
        chk({tag, "_data"}, neo_dIn, 24'h0);
        chk({tag, "_msg"}, rgb_msgTyp, 1'b0);
        chk({tag, "_ack"}, swap_ack, 1'b0);
        chk({tag, "_done"}, frame_done, 1'b0);
    endtask

    // Entered one step after the edge that moved the DUT into PRESENT.
    task automatic slot(input string tag, input logic [23:0] d, input logic m,
                        input logic last, input logic ack);
        chk({tag, "_data"}, neo_dIn, d);
        chk({tag, "_msg"}, rgb_msgTyp, m);
        chk({tag, "_valid"}, empty_flg, 1'b0);
        repeat (GAP) tick();
        chk({tag, "_hold"}, neo_dIn, d);
        rd_next = 1'b1;
        tick();
        rd_next = 1'b0;
        chk({tag, "_gap_empty"}, empty_flg, 1'b1);
        chk({tag, "_done"}, frame_done, last);
        chk({tag, "_ack"}, swap_ack, ack);
        tick();
    endtask

    task automatic run_slots(input int f, input int first, input int last_excl,
                             input int bank, input logic ack_last);
        for (int i = first; i < last_excl; i++) begin
            slot($sformatf("f%0d_s%0d", f, i),
                 (i < NPIX) ? model[bank][i] : 24'h0,
                 (i < NPIX), (i == TOTAL - 1), (i == TOTAL - 1) && ack_last);
        end
    endtask

    initial begin
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Swap while idle so bank0 becomes the back bank for preloading.
        pulse_swap();
        chk("idle_swap_ack", swap_ack, 1'b1);
        disp = 1'b1;
        tick();
        chk("idle_swap_ack_clear", swap_ack, 1'b0);
        for (int i = 0; i < NPIX; i++) wr(i, 24'h300000 + 24'(i));

        rst = 1'b1;
        tick();
        rst = 1'b0;
        disp = 1'b0;
        check_reset_outputs("reset2");

        // Test 1/2: start streaming bank0.
        run = 1'b1;
        tick();
        chk("start_fetch_empty", empty_flg, 1'b1);
        tick();
        run_slots(1, 0, TOTAL, 0, 1'b0);

        // Test 3/4: fill bank1 while slot 0 of frame 2 is on display, then request a swap twice.
        for (int i = 0; i < NPIX; i++) wr(i, 24'h000010 + 24'(i));
        wr(18, 24'hFFFFFF);
        run_slots(2, 0, 3, 0, 1'b0);
        pulse_swap();
        run_slots(2, 3, 10, 0, 1'b0);
        pulse_swap();
        run_slots(2, 10, TOTAL, 0, 1'b1);
        disp = 1'b1;

        // Frame 3 shows bank1; out-of-range write would alias onto bank1[0].
        wr(18, 24'hFFFFFF);
        wr(0, 24'h000055);
        run_slots(3, 0, TOTAL, 1, 1'b0);

        // Test 5: drop run at slot 5, frame still completes.
        run_slots(4, 0, 5, 1, 1'b0);
        run = 1'b0;
        run_slots(4, 5, TOTAL, 1, 1'b0);
        tick();
        chk("stopped_empty", empty_flg, 1'b1);
        chk("stopped_done", frame_done, 1'b0);
        pulse_swap();
        chk("idle_swap2_ack", swap_ack, 1'b1);
        disp = 1'b0;
        tick();
        chk("idle_swap2_clear", swap_ack, 1'b0);
        pulse_swap();
        chk("idle_swap3_ack", swap_ack, 1'b1);
        disp = 1'b1;

        // Test 6: reset at slot 7 with a swap pending.
        run = 1'b1;
        tick();
        chk("restart_fetch_empty", empty_flg, 1'b1);
        tick();
        run_slots(5, 0, 7, 1, 1'b0);
        pulse_swap();
        chk("slot7_valid", empty_flg, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        disp = 1'b0;
        check_reset_outputs("midframe_reset");
        tick();
        chk("no_stale_swap_ack", swap_ack, 1'b0);
        chk("post_reset_fetch_empty", empty_flg, 1'b1);
        tick();
        run_slots(6, 0, 2, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
